pkt_filter_buf: RTL and testbench
=================================

# pkt_filter_buf

Store-and-forward Avalon-ST packet filter with per-channel admission mask, length policing and commit/rollback buffering. Sits between the MAC-side Avalon-ST source and the downstream packet consumer. Whole packets are buffered; on the eop beat each packet is either committed (made visible to the output) or rolled back (erased without ever reaching the output). Pass and drop counters are exported for the control block.

## Interface
- AST_DWIDTH, 64, data bus width in bits; EMPTY_WIDTH = $clog2(AST_DWIDTH/8)
- CHANNEL_WIDTH, 2, channel field width; number of channels NCH = 2**CHANNEL_WIDTH
- BUF_AWIDTH, 8, buffer address width; depth 2**BUF_AWIDTH words
- MIN_PCKT_WORDS, 8, minimum legal packet length in words
- MAX_PCKT_WORDS, 190, maximum legal packet length in words; must be ≤ 2**BUF_AWIDTH − 1 (elaboration check)
- CNT_WIDTH, 16, statistics counter width
- clk_i  input  1  single clock, all logic on the rising edge
- arst_n_i  input  1  reset, asynchronous, active-low
- sink_if  avalon_st_if.sink  —  input stream: data, empty, channel, startofpacket, endofpacket, valid, ready
- src_if  avalon_st_if.src  —  output stream, same signal set, ready latency 0
- chan_en_i  input  NCH  admission mask; bit c=1 admits channel c
- clr_cnt_i  input  1  synchronous clear of both counters
- pass_cnt_o  output  CNT_WIDTH  committed packets, saturating
- drop_cnt_o  output  CNT_WIDTH  rolled-back packets, saturating

## Operation
- Buffer word = {sop, eop, channel, empty, data}; channel is carried through to src_if.channel.
- Write side: wr_ptr (speculative), commit_ptr, pkt_start; read side: rd_ptr. All pointers BUF_AWIDTH+1 bits, wrap naturally.
- Input FSM: IDLE_S, RCV_S, DISCARD_S.
  - IDLE_S: beat with valid&ready&sop → write word, pkt_start←wr_ptr, len←1, sample chan_ok = chan_en_i[channel] → RCV_S (or eval immediately if eop on the same beat). Non-sop beats are accepted and ignored.
  - RCV_S: each accepted beat written, len+1. If len reaches MAX_PCKT_WORDS without eop → DISCARD_S, flag long.
  - DISCARD_S: beats accepted but not written until eop → rollback, IDLE_S.
  - sop while in RCV_S/DISCARD_S: current packet rolled back (drop_cnt+1), new packet started on the same beat.
- Eop evaluation: commit iff chan_ok && MIN_PCKT_WORDS ≤ len ≤ MAX_PCKT_WORDS && !long. Commit: commit_ptr←wr_ptr+1 (including the eop word), pass_cnt+1. Rollback: wr_ptr←pkt_start, drop_cnt+1.
- sink_if.ready = !full || state==DISCARD_S, where full = (wr_ptr − rd_ptr) == 2**BUF_AWIDTH. Forward progress is guaranteed because MAX_PCKT_WORDS < depth.
- Read side: words between rd_ptr and commit_ptr are visible. Synchronous memory read plus a 2-entry output stage sustain 1 word/clk while src_if.ready=1. src_if.valid is held with stable data until accepted.
- Counters saturate at all-ones. clr_cnt_i has priority over an increment in the same cycle.

## Timing
- Reset (arst_n_i=0, asynchronous): all pointers 0, FSM IDLE_S, src_if.valid=0, sink_if.ready=0, pass_cnt_o=drop_cnt_o=0. ready=1 from the first edge after release. Reset mid-packet discards all buffer contents.
- Latency: eop accepted at edge N → commit_ptr updated at edge N. Sop word valid on src_if after edge N+2, provided the output stage is empty.
- Counters update at the edge that accepts the eop (or the truncating sop).
- src_if.startofpacket/endofpacket/empty/channel/data are don't-care while valid=0. src_if.channel reflects the stored channel, never forced to 0.
- Simultaneous read at full and eop commit: both take effect, and ready recomputes the next cycle.
- chan_en_i changes affect only packets whose sop arrives after the change.

## Structure
- Package pkt_filter_pkg: fsm state enum, buffer word struct typedef, helper function word_w(AST_DWIDTH, CHANNEL_WIDTH).
- Sub-module pkt_cr_fifo: dual-pointer FIFO with commit/rollback ports (wr, commit, rollback, rd, rddata, full, empty). The top level holds the FSM, policing, output stage and counters.

## Test plan
- Channel 1 enabled, 20-word packet, src_if.ready=1 → 20 words out, sop on word 0, eop on word 19, channel=1, pass_cnt_o=1.
- chan_en_i=4'b1101, 10-word packet on channel 1 → no output, drop_cnt_o=1. Following channel 0 packet passes intact.
- Lengths 7, 8, 190, 191 words on an enabled channel → only 8 and 190 delivered, drop_cnt_o=2, 191-word packet: ready stays 1 through the discard.
- src_if.ready=0 while 300 words of 30-word packets arrive → ready drops at 256 buffered words. Releasing ready delivers every committed packet in order, no loss.
- Sop mid-packet after 12 words → first packet dropped (drop_cnt_o=1), second delivered whole.
- arst_n_i pulsed low mid-transfer → valid=0 and counters=0 immediately. Next packet after release passes normally.

Source files
------------

// File: rtl/pkt_filter_pkg.sv
// Shared types for the store-and-forward packet filter.
// FSM states, buffer word control bits and the word width helper.
package pkt_filter_pkg;

  typedef enum logic [1:0] {
    IDLE_S,
    RCV_S,
    DISCARD_S
  } fsm_state_e;

  typedef struct packed {
    logic sop;
    logic eop;
  } word_ctl_t;

  function automatic int word_w(input int dwidth, input int cwidth);
    return 2 + cwidth + $clog2(dwidth / 8) + dwidth;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle with data, empty, channel and framing.
// Ready latency 0 on both directions.
interface avalon_st_if #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 2,
  parameter int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8)
);

  logic [AST_DWIDTH-1:0]    data;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic                     startofpacket;
  logic                     endofpacket;
  logic                     valid;
  logic                     ready;

  modport sink (
    input  data, empty, channel,
    input  startofpacket, endofpacket, valid,
    output ready
  );

  modport src (
    output data, empty, channel,
    output startofpacket, endofpacket, valid,
    input  ready
  );

endinterface

// File: rtl/pkt_cr_fifo.sv
// FIFO with a speculative write pointer and commit/rollback control.
// Only words below the commit pointer are visible to the read side.
module pkt_cr_fifo #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          mark_i,
  input  logic          restart_i,
  input  logic          commit_i,
  input  logic          rollback_i,
  input  logic          rd_i,
  output logic [DW-1:0] rddata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] start_ptr_q, start_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] base, after;

  // restart drops the open packet before the new sop word lands
  always_comb begin
    base         = restart_i ? start_ptr_q : wr_ptr_q;
    after        = wr_i ? base + ONE : base;
    start_ptr_d  = mark_i ? base : start_ptr_q;
    wr_ptr_d     = rollback_i ? start_ptr_d : after;
    commit_ptr_d = commit_i ? after : commit_ptr_q;
    rd_ptr_d     = rd_i ? rd_ptr_q + ONE : rd_ptr_q;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      start_ptr_q  <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      start_ptr_q  <= start_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_i) mem[base[AW-1:0]] <= wdata_i;
    if (rd_i) rdata_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign rddata_o = rdata_q;
  assign full_o   = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  assign empty_o  = rd_ptr_q == commit_ptr_q;

endmodule

// File: rtl/pkt_filter_buf.sv
// Store-and-forward Avalon-ST filter: channel mask, length policing,
// commit/rollback buffering and saturating pass/drop counters.
module pkt_filter_buf
  import pkt_filter_pkg::*;
#(
  parameter int AST_DWIDTH     = 64,
  parameter int CHANNEL_WIDTH  = 2,
  parameter int BUF_AWIDTH     = 8,
  parameter int MIN_PCKT_WORDS = 8,
  parameter int MAX_PCKT_WORDS = 190,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  avalon_st_if.sink                     sink_if,
  avalon_st_if.src                      src_if,
  input  logic [2**CHANNEL_WIDTH-1:0]   chan_en_i,
  input  logic                          clr_cnt_i,
  output logic [CNT_WIDTH-1:0]          pass_cnt_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o
);

  localparam int EMPTY_WIDTH = $clog2(AST_DWIDTH / 8);
  localparam int LW          = BUF_AWIDTH + 1;
  localparam int WW          = word_w(AST_DWIDTH, CHANNEL_WIDTH);

  localparam logic [LW-1:0] ONE   = LW'(1);
  localparam logic [LW-1:0] MIN_L = LW'(MIN_PCKT_WORDS);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_PCKT_WORDS);

  if (MAX_PCKT_WORDS > 2**BUF_AWIDTH - 1) begin : g_bad_max
    $error("MAX_PCKT_WORDS must be below the buffer depth");
  end

  typedef struct packed {
    word_ctl_t                ctl;
    logic [CHANNEL_WIDTH-1:0] channel;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [AST_DWIDTH-1:0]    data;
  } buf_word_t;

  fsm_state_e      state_q, state_d;
  logic [LW-1:0]   len_q, len_d, len_n;
  logic            chan_ok_q, chan_ok_d, chan_ok_n;
  logic            long_q, long_d;
  logic            rdy_en_q;

  logic            beat, full, fifo_empty;
  logic            wr, mark, restart, commit, rollback, rd;
  logic            eval, pass_ok;
  buf_word_t       in_w, rd_w;
  logic [WW-1:0]   rd_raw;

  assign in_w = {sink_if.startofpacket, sink_if.endofpacket,
                 sink_if.channel, sink_if.empty, sink_if.data};
  assign rd_w = rd_raw;

  assign sink_if.ready = rdy_en_q && (!full || state_q == DISCARD_S);
  assign beat          = sink_if.valid && sink_if.ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    chan_ok_d = chan_ok_q;
    long_d    = long_q;
    wr        = 1'b0;
    mark      = 1'b0;
    restart   = 1'b0;
    eval      = 1'b0;
    pass_ok   = 1'b0;
    chan_ok_n = chan_en_i[sink_if.channel];
    len_n     = len_q + ONE;
    if (beat) begin
      if (sink_if.startofpacket) begin
        restart   = state_q != IDLE_S;
        wr        = 1'b1;
        mark      = 1'b1;
        len_d     = ONE;
        chan_ok_d = chan_ok_n;
        long_d    = 1'b0;
        if (sink_if.endofpacket) begin
          eval    = 1'b1;
          pass_ok = chan_ok_n && MIN_L <= ONE && ONE <= MAX_L;
          state_d = IDLE_S;
        end else if (ONE == MAX_L) begin
          long_d  = 1'b1;
          state_d = DISCARD_S;
        end else begin
          state_d = RCV_S;
        end
      end else begin
        unique case (state_q)
          RCV_S: begin
            wr    = 1'b1;
            len_d = len_n;
            if (sink_if.endofpacket) begin
              eval    = 1'b1;
              pass_ok = chan_ok_q && !long_q &&
                        MIN_L <= len_n && len_n <= MAX_L;
              state_d = IDLE_S;
            end else if (len_n == MAX_L) begin
              long_d  = 1'b1;
              state_d = DISCARD_S;
            end
          end
          DISCARD_S: begin
            if (sink_if.endofpacket) begin
              eval    = 1'b1;
              state_d = IDLE_S;
            end
          end
          default: ;
        endcase
      end
    end
    commit   = eval && pass_ok;
    rollback = eval && !pass_ok;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE_S;
      len_q     <= '0;
      chan_ok_q <= 1'b0;
      long_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      chan_ok_q <= chan_ok_d;
      long_q    <= long_d;
      rdy_en_q  <= 1'b1;
    end
  end

  pkt_cr_fifo #(
    .DW (WW),
    .AW (BUF_AWIDTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .wr_i       (wr),
    .wdata_i    (in_w),
    .mark_i     (mark),
    .restart_i  (restart),
    .commit_i   (commit),
    .rollback_i (rollback),
    .rd_i       (rd),
    .rddata_o   (rd_raw),
    .full_o     (full),
    .empty_o    (fifo_empty)
  );

  // two-entry output stage absorbs the one-cycle RAM read latency
  logic [1:0] ob_cnt_q, ob_cnt_d;
  logic       rd_pend_q;
  buf_word_t  ob0_q, ob0_d, ob1_q, ob1_d;
  logic       pop;
  logic [2:0] occ;

  assign pop = ob_cnt_q != 2'd0 && src_if.ready;
  assign occ = {1'b0, ob_cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign rd  = !fifo_empty && occ < 3'd2;

  always_comb begin
    ob0_d    = ob0_q;
    ob1_d    = ob1_q;
    ob_cnt_d = ob_cnt_q;
    if (pop) begin
      ob0_d    = ob1_q;
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
    if (rd_pend_q) begin
      if (ob_cnt_d == 2'd0) ob0_d = rd_w;
      else                  ob1_d = rd_w;
      ob_cnt_d = ob_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ob_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      ob0_q     <= '0;
      ob1_q     <= '0;
    end else begin
      ob_cnt_q  <= ob_cnt_d;
      rd_pend_q <= rd;
      ob0_q     <= ob0_d;
      ob1_q     <= ob1_d;
    end
  end

  assign src_if.valid         = ob_cnt_q != 2'd0;
  assign src_if.startofpacket = ob0_q.ctl.sop;
  assign src_if.endofpacket   = ob0_q.ctl.eop;
  assign src_if.channel       = ob0_q.channel;
  assign src_if.empty         = ob0_q.empty;
  assign src_if.data          = ob0_q.data;

  logic [CNT_WIDTH-1:0] pass_q, pass_d, drop_q, drop_d;
  logic [CNT_WIDTH:0]   pass_sum, drop_sum;
  logic [1:0]           drop_inc;

  assign drop_inc = {1'b0, restart} + {1'b0, rollback};

  always_comb begin
    pass_sum = {1'b0, pass_q} + {{CNT_WIDTH{1'b0}}, commit};
    drop_sum = {1'b0, drop_q} + {{(CNT_WIDTH-1){1'b0}}, drop_inc};
    pass_d   = pass_sum[CNT_WIDTH] ? '1 : pass_sum[CNT_WIDTH-1:0];
    drop_d   = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    if (clr_cnt_i) begin
      pass_d = '0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pass_q <= '0;
      drop_q <= '0;
    end else begin
      pass_q <= pass_d;
      drop_q <= drop_d;
    end
  end

  assign pass_cnt_o = pass_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_pkt_filter_buf.sv
// Scoreboard bench for pkt_filter_buf: expected words are queued
// when driven and compared as they leave src_if.
module tb_pkt_filter_buf;

  localparam int DW    = 64;
  localparam int CW    = 2;
  localparam int EW    = 3;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int CNTW  = 16;

  typedef logic [2+CW+EW+DW-1:0] word_t;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  logic [3:0] chan_en;
  logic clr_cnt;
  logic [CNTW-1:0] pass_cnt, drop_cnt;

  always #5 clk = ~clk;

  avalon_st_if #(.AST_DWIDTH(DW), .CHANNEL_WIDTH(CW)) sink_if ();
  avalon_st_if #(.AST_DWIDTH(DW), .CHANNEL_WIDTH(CW)) src_if ();

  pkt_filter_buf #(
    .AST_DWIDTH     (DW),
    .CHANNEL_WIDTH  (CW),
    .BUF_AWIDTH     (AW),
    .MIN_PCKT_WORDS (8),
    .MAX_PCKT_WORDS (190),
    .CNT_WIDTH      (CNTW)
  ) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .sink_if    (sink_if),
    .src_if     (src_if),
    .chan_en_i  (chan_en),
    .clr_cnt_i  (clr_cnt),
    .pass_cnt_o (pass_cnt),
    .drop_cnt_o (drop_cnt)
  );

  word_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int rx_words = 0;
  int acc_words = 0;
  bit drv_done;

  always @(negedge clk) begin
    word_t got, exp;
    if (arst_n && src_if.valid && src_if.ready) begin
      got = {src_if.startofpacket, src_if.endofpacket, src_if.channel,
             src_if.empty, src_if.data};
      rx_words++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got %h, required no word", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL rx_word: got %h, required %h", got, exp);
        end
      end
    end
  end

  task automatic send_pkt(input int ch, input int len, input bit pass,
                          input bit term, output int stalls);
    word_t w;
    bit acc;
    int n;
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      sink_if.valid         = 1'b1;
      sink_if.startofpacket = (i == 0);
      sink_if.endofpacket   = term && (i == len - 1);
      sink_if.channel       = CW'(ch);
      sink_if.empty         = sink_if.endofpacket ? EW'($urandom) : '0;
      sink_if.data          = {$urandom, $urandom};
      w = {sink_if.startofpacket, sink_if.endofpacket, sink_if.channel,
           sink_if.empty, sink_if.data};
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = sink_if.ready;
        if (!acc) stalls++;
        @(posedge clk);
        #1;
        n++;
        if (!acc && n > 3000) begin
          checks++;
          errors++;
          $display("FAIL sink_timeout: ready=%0b, required 1", sink_if.ready);
          sink_if.valid = 1'b0;
          return;
        end
      end
      acc_words++;
      if (pass) exp_q.push_back(w);
    end
    sink_if.valid = 1'b0;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 3000 && (exp_q.size() != 0 || src_if.valid); n++)
      @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words left, required 0", name, exp_q.size());
    end
  endtask

  task automatic chk_cnt(input string name, input int ep, input int ed);
    checks++;
    if (pass_cnt !== CNTW'(ep)) begin
      errors++;
      $display("FAIL %s_pass_cnt: got %0d, required %0d", name, pass_cnt, ep);
    end
    checks++;
    if (drop_cnt !== CNTW'(ed)) begin
      errors++;
      $display("FAIL %s_drop_cnt: got %0d, required %0d", name, drop_cnt, ed);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #2;
    checks++;
    if (src_if.valid !== 1'b0 || sink_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: valid=%b ready=%b, required 0 0",
               src_if.valid, sink_if.ready);
    end
    chk_cnt("reset", 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    checks++;
    if (sink_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: got %b, required 0", sink_if.ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sink_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_release: got %b, required 1", sink_if.ready);
    end
  endtask

  task automatic test_basic();
    int s, rx0;
    chan_en = 4'b0010;
    src_if.ready = 1'b1;
    clear_counters();
    rx0 = rx_words;
    send_pkt(1, 20, 1, 1, s);
    @(posedge clk);
    #1;
    checks++;
    if (src_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat_n1: valid=%b, required 0", src_if.valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (src_if.valid !== 1'b1 || src_if.startofpacket !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat_n2: valid=%b sop=%b, required 1 1",
               src_if.valid, src_if.startofpacket);
    end
    drain("basic");
    checks++;
    if (rx_words - rx0 != 20) begin
      errors++;
      $display("FAIL basic_words: got %0d, required 20", rx_words - rx0);
    end
    chk_cnt("basic", 1, 0);
  endtask

  task automatic test_chan_mask();
    int s;
    chan_en = 4'b1101;
    clear_counters();
    chk_cnt("clear", 0, 0);
    send_pkt(1, 10, 0, 1, s);
    send_pkt(0, 8, 1, 1, s);
    drain("mask");
    chk_cnt("mask", 1, 1);
  endtask

  task automatic test_lengths();
    int s;
    chan_en = 4'b1111;
    clear_counters();
    send_pkt(2, 7, 0, 1, s);
    send_pkt(2, 8, 1, 1, s);
    send_pkt(2, 190, 1, 1, s);
    send_pkt(2, 191, 0, 1, s);
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL long_ready: %0d stall cycles, required 0", s);
    end
    drain("lengths");
    chk_cnt("lengths", 2, 2);
  endtask

  task automatic test_backpressure();
    int acc0, rx0, at_low;
    bit seen;
    chan_en = 4'b0001;
    src_if.ready = 1'b0;
    clear_counters();
    acc0 = acc_words;
    rx0 = rx_words;
    drv_done = 1'b0;
    fork
      begin
        int s;
        for (int k = 0; k < 10; k++) send_pkt(0, 30, 1, 1, s);
        drv_done = 1'b1;
      end
    join_none
    seen = 1'b0;
    at_low = 0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      if (!sink_if.ready) begin
        seen = 1'b1;
        at_low = acc_words - acc0;
      end
    end
    checks++;
    if (!seen || at_low != DEPTH + 2) begin
      errors++;
      $display("FAIL bp_full_level: seen=%0b accepted=%0d, required 1 %0d",
               seen, at_low, DEPTH + 2);
    end
    repeat (5) @(posedge clk);
    #1;
    src_if.ready = 1'b1;
    for (int n = 0; n < 3000 && !drv_done; n++) @(posedge clk);
    checks++;
    if (!drv_done) begin
      errors++;
      $display("FAIL bp_driver: done=%0b, required 1", drv_done);
    end
    drain("bp");
    checks++;
    if (rx_words - rx0 != 300) begin
      errors++;
      $display("FAIL bp_words: got %0d, required 300", rx_words - rx0);
    end
    chk_cnt("bp", 10, 0);
  endtask

  task automatic test_truncate();
    int s;
    chan_en = 4'b0001;
    clear_counters();
    send_pkt(0, 12, 0, 0, s);
    send_pkt(0, 15, 1, 1, s);
    drain("trunc");
    chk_cnt("trunc", 1, 1);
  endtask

  task automatic test_reset_mid();
    int s;
    chan_en = 4'b0001;
    src_if.ready = 1'b0;
    clear_counters();
    send_pkt(0, 20, 1, 1, s);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (src_if.valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_valid: got %b, required 1", src_if.valid);
    end
    chk_cnt("rst_pre", 1, 0);
    send_pkt(0, 5, 0, 0, s);
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (src_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_valid: got %b, required 0", src_if.valid);
    end
    chk_cnt("rst_mid", 0, 0);
    exp_q.delete();
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    src_if.ready = 1'b1;
    send_pkt(0, 10, 1, 1, s);
    drain("rst_post");
    chk_cnt("rst_post", 1, 0);
  endtask

  initial begin
    chan_en = 4'b0000;
    clr_cnt = 1'b0;
    sink_if.valid = 1'b0;
    sink_if.startofpacket = 1'b0;
    sink_if.endofpacket = 1'b0;
    sink_if.channel = '0;
    sink_if.empty = '0;
    sink_if.data = '0;
    src_if.ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_chan_mask();
    test_lengths();
    test_backpressure();
    test_truncate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
